// File: rtl/lcd_bus_pkg.sv
// Shared constants, opcode masks and decode helpers for the HD44780-style bus responder.
// Covers the DDRAM address map, the AC wrap points and instruction classification.
package lcd_bus_pkg;

   localparam logic [6:0] LINE1_BASE   = 7'h00;
   localparam logic [6:0] LINE2_BASE   = 7'h40;
   localparam int         LINE_LEN     = 16;
   localparam int         DDRAM_DEPTH  = 2 * LINE_LEN;
   localparam int         CLEAR_CYCLES = 32;
   localparam logic [7:0] SPACE        = 8'h20;
   localparam logic [6:0] WRAP_HI1     = 7'h27;
   localparam logic [6:0] WRAP_HI2     = 7'h67;

   localparam logic [7:0] OP_SET_DDRAM = 8'h80;
   localparam logic [7:0] OP_SET_CGRAM = 8'h40;
   localparam logic [7:0] OP_FUNC_SET  = 8'h20;
   localparam logic [7:0] OP_SHIFT     = 8'h10;
   localparam logic [7:0] OP_DISP_CTRL = 8'h08;
   localparam logic [7:0] OP_ENTRY     = 8'h04;
   localparam logic [7:0] OP_HOME      = 8'h02;
   localparam logic [7:0] OP_CLEAR     = 8'h01;

   typedef enum logic [3:0] {
      INS_NOP,
      INS_CLEAR,
      INS_HOME,
      INS_ENTRY,
      INS_DISP,
      INS_SHIFT,
      INS_FUNC,
      INS_CGRAM,
      INS_DDRAM
   } ins_e;

   typedef enum logic {
      ST_IDLE,
      ST_CLEAR
   } state_e;

   typedef struct packed {
      logic       valid;
      logic [4:0] idx;
   } ddram_ref_t;

   // The highest set opcode bit selects the instruction.
   function automatic ins_e decode_ins(input logic [7:0] d);
      if      ((d & OP_SET_DDRAM) != 8'h00) return INS_DDRAM;
      else if ((d & OP_SET_CGRAM) != 8'h00) return INS_CGRAM;
      else if ((d & OP_FUNC_SET)  != 8'h00) return INS_FUNC;
      else if ((d & OP_SHIFT)     != 8'h00) return INS_SHIFT;
      else if ((d & OP_DISP_CTRL) != 8'h00) return INS_DISP;
      else if ((d & OP_ENTRY)     != 8'h00) return INS_ENTRY;
      else if ((d & OP_HOME)      != 8'h00) return INS_HOME;
      else if ((d & OP_CLEAR)     != 8'h00) return INS_CLEAR;
      else                                  return INS_NOP;
   endfunction

   function automatic ddram_ref_t map_ac(input logic [6:0] ac);
      ddram_ref_t r;
      r.idx   = {ac[6], ac[3:0]};
      r.valid = (ac[6:4] == LINE1_BASE[6:4]) || (ac[6:4] == LINE2_BASE[6:4]);
      return r;
   endfunction

endpackage

// File: rtl/lcd_ac_step.sv
// Next address-counter value for one step in either direction.
// Wraps line 1 end into line 2 and back; unmapped values step mod 128.
module lcd_ac_step
   import lcd_bus_pkg::*;
(
   input  logic [6:0] ac,
   input  logic       inc,
   output logic [6:0] ac_next
);

   always_comb begin
      ac_next = inc ? (ac + 7'd1) : (ac - 7'd1);
      if (inc && (ac == WRAP_HI1))        ac_next = LINE2_BASE;
      else if (inc && (ac == WRAP_HI2))   ac_next = LINE1_BASE;
      else if (!inc && (ac == LINE2_BASE)) ac_next = WRAP_HI1;
      else if (!inc && (ac == LINE1_BASE)) ac_next = WRAP_HI2;
   end

endmodule

// File: rtl/lcd_bus_responder.sv
// Display-side responder for the 8-bit LCD bus: decodes writes into DDRAM/AC/mode state,
// answers status and data reads, and exposes DDRAM through a registered side port.
module lcd_bus_responder
   import lcd_bus_pkg::*;
#(
   parameter int BUSY_SHORT = 0,
   parameter int BUSY_LONG  = 0
)
(
   input  logic       CLK,
   input  logic       RESETN,
   input  logic       LCD_E,
   input  logic       LCD_RS,
   input  logic       LCD_RW,
   input  logic [7:0] LCD_DATA_IN,
   output logic [7:0] LCD_DATA_OUT,
   output logic       LCD_DATA_OE,
   input  logic [4:0] RD_ADDR,
   output logic [7:0] RD_CHAR,
   output logic [6:0] CUR_ADDR,
   output logic       DISP_ON,
   output logic       CURSOR_ON,
   output logic       BLINK_ON,
   output logic       ENTRY_ID,
   output logic       ENTRY_S,
   output logic       LINES2,
   output logic       BUSY,
   output logic       ERR_BUSY
);

   localparam int BUSY_W = 16;
   localparam logic [BUSY_W-1:0] SHORT_LD = BUSY_W'(BUSY_SHORT);
   localparam logic [BUSY_W-1:0] HOME_LD  = BUSY_W'(BUSY_LONG);
   localparam logic [BUSY_W-1:0] CLEAR_LD =
      (BUSY_LONG > CLEAR_CYCLES) ? BUSY_W'(BUSY_LONG) : BUSY_W'(CLEAR_CYCLES);

   logic              e1_q, e1_d, e2_q, e2_d, e2_prev_q, e2_prev_d;
   logic              rs_q, rs_d, rw_q, rw_d;
   logic [7:0]        data_q, data_d;
   logic [6:0]        ac_q, ac_d;
   logic              entry_id_q, entry_id_d, entry_s_q, entry_s_d;
   logic              disp_on_q, disp_on_d, cursor_on_q, cursor_on_d;
   logic              blink_on_q, blink_on_d, lines2_q, lines2_d;
   logic [BUSY_W-1:0] busy_cnt_q, busy_cnt_d;
   logic              err_busy_q, err_busy_d;
   state_e            state_q, state_d;
   logic [4:0]        clr_idx_q, clr_idx_d;
   logic [7:0]        ddram_q [DDRAM_DEPTH];
   logic [7:0]        ddram_d [DDRAM_DEPTH];
   logic [7:0]        data_out_q, data_out_d;
   logic              data_oe_q, data_oe_d;
   logic [7:0]        rd_char_q, rd_char_d;

   logic       busy, fall, read_now, is_shift, step_inc;
   ins_e       ins;
   ddram_ref_t ac_ref;
   logic [6:0] ac_stepped;

   assign busy     = (busy_cnt_q != '0);
   assign fall     = e2_prev_q & ~e2_q;
   assign read_now = e1_q & LCD_RW;
   assign ins      = decode_ins(data_q);
   assign ac_ref   = map_ac(ac_q);
   assign is_shift = ~rs_q & ~rw_q & (ins == INS_SHIFT);
   // Cursor shift takes its direction from the opcode; data accesses follow entry mode.
   assign step_inc = is_shift ? data_q[2] : entry_id_q;

   lcd_ac_step u_ac_step (
      .ac      (ac_q),
      .inc     (step_inc),
      .ac_next (ac_stepped)
   );

   // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
   always_comb begin
      e1_d        = LCD_E;
      e2_d        = e1_q;
      e2_prev_d   = e2_q;
      rs_d        = e2_q ? LCD_RS      : rs_q;
      rw_d        = e2_q ? LCD_RW      : rw_q;
      data_d      = e2_q ? LCD_DATA_IN : data_q;
      ac_d        = ac_q;
      entry_id_d  = entry_id_q;
      entry_s_d   = entry_s_q;
      disp_on_d   = disp_on_q;
      cursor_on_d = cursor_on_q;
      blink_on_d  = blink_on_q;
      lines2_d    = lines2_q;
      busy_cnt_d  = busy ? (busy_cnt_q - BUSY_W'(1)) : busy_cnt_q;
      err_busy_d  = err_busy_q;
      state_d     = state_q;
      clr_idx_d   = clr_idx_q;
      ddram_d     = ddram_q;
      data_oe_d   = read_now;
      data_out_d  = 8'h00;
      rd_char_d   = ddram_q[RD_ADDR];

      case (state_q)
         ST_CLEAR: begin
            ddram_d[clr_idx_q] = SPACE;
            clr_idx_d          = clr_idx_q + 5'd1;
            if (clr_idx_q == 5'(DDRAM_DEPTH - 1)) state_d = ST_IDLE;
         end
         default: ;
      endcase

      if (fall) begin
         if (rw_q) begin
            if (rs_q) ac_d = ac_stepped;
         end else if (busy) begin
            err_busy_d = 1'b1;
         end else if (rs_q) begin
            busy_cnt_d = SHORT_LD;
            if (ac_ref.valid) ddram_d[ac_ref.idx] = data_q;
            ac_d = ac_stepped;
         end else begin
            busy_cnt_d = SHORT_LD;
            case (ins)
               INS_DDRAM: ac_d = data_q[6:0];
               INS_FUNC:  lines2_d = data_q[3];
               INS_SHIFT: if (!data_q[3]) ac_d = ac_stepped;
               INS_DISP: begin
                  disp_on_d   = data_q[2];
                  cursor_on_d = data_q[1];
                  blink_on_d  = data_q[0];
               end
               INS_ENTRY: begin
                  entry_id_d = data_q[1];
                  entry_s_d  = data_q[0];
               end
               INS_HOME: begin
                  ac_d       = 7'h00;
                  busy_cnt_d = HOME_LD;
               end
               INS_CLEAR: begin
                  ac_d       = 7'h00;
                  entry_id_d = 1'b1;
                  busy_cnt_d = CLEAR_LD;
                  clr_idx_d  = 5'd0;
                  state_d    = ST_CLEAR;
               end
               default: ;
            endcase
         end
      end

      if (read_now) begin
         if (LCD_RS) data_out_d = ac_ref.valid ? ddram_q[ac_ref.idx] : SPACE;
         else        data_out_d = {busy, ac_q};
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         e1_q        <= 1'b0;
         e2_q        <= 1'b0;
         e2_prev_q   <= 1'b0;
         rs_q        <= 1'b0;
         rw_q        <= 1'b0;
         data_q      <= 8'h00;
         ac_q        <= 7'h00;
         entry_id_q  <= 1'b1;
         entry_s_q   <= 1'b0;
         disp_on_q   <= 1'b0;
         cursor_on_q <= 1'b0;
         blink_on_q  <= 1'b0;
         lines2_q    <= 1'b0;
         busy_cnt_q  <= '0;
         err_busy_q  <= 1'b0;
         state_q     <= ST_IDLE;
         clr_idx_q   <= 5'd0;
         // NOTE: DDRAM is a small flop array, so it is reset directly instead of via a clear sweep.
         ddram_q     <= '{default: SPACE};
         data_out_q  <= 8'h00;
         data_oe_q   <= 1'b0;
         rd_char_q   <= 8'h00;
      end else begin
         e1_q        <= e1_d;
         e2_q        <= e2_d;
         e2_prev_q   <= e2_prev_d;
         rs_q        <= rs_d;
         rw_q        <= rw_d;
         data_q      <= data_d;
         ac_q        <= ac_d;
         entry_id_q  <= entry_id_d;
         entry_s_q   <= entry_s_d;
         disp_on_q   <= disp_on_d;
         cursor_on_q <= cursor_on_d;
         blink_on_q  <= blink_on_d;
         lines2_q    <= lines2_d;
         busy_cnt_q  <= busy_cnt_d;
         err_busy_q  <= err_busy_d;
         state_q     <= state_d;
         clr_idx_q   <= clr_idx_d;
         ddram_q     <= ddram_d;
         data_out_q  <= data_out_d;
         data_oe_q   <= data_oe_d;
         rd_char_q   <= rd_char_d;
      end
   end

   assign LCD_DATA_OUT = data_out_q;
   assign LCD_DATA_OE  = data_oe_q;
   assign RD_CHAR      = rd_char_q;
   assign CUR_ADDR     = ac_q;
   assign DISP_ON      = disp_on_q;
   assign CURSOR_ON    = cursor_on_q;
   assign BLINK_ON     = blink_on_q;
   assign ENTRY_ID     = entry_id_q;
   assign ENTRY_S      = entry_s_q;
   assign LINES2       = lines2_q;
   assign BUSY         = busy;
   assign ERR_BUSY     = err_busy_q;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Directed bench for lcd_bus_responder: drives bus cycles and checks state, reads and DDRAM
// contents against hand-computed values.
module tb_lcd_bus_responder;

   logic       CLK = 1'b0;
   logic       RESETN;
   logic       LCD_E, LCD_RS, LCD_RW;
   logic [7:0] LCD_DATA_IN, LCD_DATA_OUT;
   logic       LCD_DATA_OE;
   logic [4:0] RD_ADDR;
   logic [7:0] RD_CHAR;
   logic [6:0] CUR_ADDR;
   logic       DISP_ON, CURSOR_ON, BLINK_ON, ENTRY_ID, ENTRY_S, LINES2, BUSY, ERR_BUSY;

   int checks = 0;
   int errors = 0;

   lcd_bus_responder dut (
      .CLK          (CLK),
      .RESETN       (RESETN),
      .LCD_E        (LCD_E),
      .LCD_RS       (LCD_RS),
      .LCD_RW       (LCD_RW),
      .LCD_DATA_IN  (LCD_DATA_IN),
      .LCD_DATA_OUT (LCD_DATA_OUT),
      .LCD_DATA_OE  (LCD_DATA_OE),
      .RD_ADDR      (RD_ADDR),
      .RD_CHAR      (RD_CHAR),
      .CUR_ADDR     (CUR_ADDR),
      .DISP_ON      (DISP_ON),
      .CURSOR_ON    (CURSOR_ON),
      .BLINK_ON     (BLINK_ON),
      .ENTRY_ID     (ENTRY_ID),
      .ENTRY_S      (ENTRY_S),
      .LINES2       (LINES2),
      .BUSY         (BUSY),
      .ERR_BUSY     (ERR_BUSY)
   );

   always #5 CLK = ~CLK;

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic rs, input logic [7:0] d);
      LCD_RS = rs; LCD_RW = 1'b0; LCD_DATA_IN = d; LCD_E = 1'b1;
      tick(4);
      LCD_E = 1'b0;
      tick(6);
   endtask

   task automatic bus_read(input logic rs, output logic [7:0] d, output logic oe);
      LCD_RS = rs; LCD_RW = 1'b1; LCD_DATA_IN = 8'h00; LCD_E = 1'b1;
      tick(4);
      d  = LCD_DATA_OUT;
      oe = LCD_DATA_OE;
      LCD_E = 1'b0;
      tick(6);
      LCD_RW = 1'b0;
   endtask

   task automatic side_check(input int idx, input logic [7:0] exp);
      RD_ADDR = 5'(idx);
      tick(1);
      check($sformatf("rd_char[%0d]", idx), {24'h0, RD_CHAR}, {24'h0, exp});
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] rd;
      logic       oe;
      int         wait_cnt;

      RESETN = 1'b0; LCD_E = 1'b0; LCD_RS = 1'b0; LCD_RW = 1'b0;
      LCD_DATA_IN = 8'h00; RD_ADDR = 5'd0;
      tick(3);
      check("rst_cur_addr", {25'h0, CUR_ADDR}, 32'h00);
      check("rst_entry_id", {31'h0, ENTRY_ID}, 32'h1);
      check("rst_entry_s",  {31'h0, ENTRY_S},  32'h0);
      check("rst_disp_on",  {31'h0, DISP_ON},  32'h0);
      check("rst_lines2",   {31'h0, LINES2},   32'h0);
      check("rst_busy",     {31'h0, BUSY},     32'h0);
      check("rst_err_busy", {31'h0, ERR_BUSY}, 32'h0);
      check("rst_oe",       {31'h0, LCD_DATA_OE}, 32'h0);
      check("rst_data_out", {24'h0, LCD_DATA_OUT}, 32'h00);
      check("rst_rd_char",  {24'h0, RD_CHAR},  32'h00);
      RESETN = 1'b1;
      tick(2);
      side_check(5, 8'h20);

      // Initialisation sequence.
      bus_write(1'b0, 8'h3C);
      bus_write(1'b0, 8'h0C);
      bus_write(1'b0, 8'h06);
      check("init_lines2",    {31'h0, LINES2},    32'h1);
      check("init_disp_on",   {31'h0, DISP_ON},   32'h1);
      check("init_cursor_on", {31'h0, CURSOR_ON}, 32'h0);
      check("init_blink_on",  {31'h0, BLINK_ON},  32'h0);
      check("init_entry_id",  {31'h0, ENTRY_ID},  32'h1);
      check("init_cur_addr",  {25'h0, CUR_ADDR},  32'h00);

      // Two characters on line 1.
      bus_write(1'b0, 8'h80);
      bus_write(1'b1, 8'h41);
      bus_write(1'b1, 8'h42);
      side_check(0, 8'h41);
      side_check(1, 8'h42);
      check("line1_cur_addr", {25'h0, CUR_ADDR}, 32'h02);

      // Cursor shift left then right.
      bus_write(1'b0, 8'h10);
      check("shift_left_ac", {25'h0, CUR_ADDR}, 32'h01);
      bus_write(1'b0, 8'h14);
      check("shift_right_ac", {25'h0, CUR_ADDR}, 32'h02);

      // Status read and DDRAM read.
      bus_read(1'b0, rd, oe);
      check("status_data", {24'h0, rd}, 32'h02);
      check("status_oe",   {31'h0, oe}, 32'h1);
      check("oe_after_read", {31'h0, LCD_DATA_OE}, 32'h0);
      bus_write(1'b0, 8'h80);
      bus_read(1'b1, rd, oe);
      check("data_read", {24'h0, rd}, 32'h41);
      check("data_read_ac", {25'h0, CUR_ADDR}, 32'h01);

      // Line 2 fill, then an overrun byte at the unmapped 0x50.
      bus_write(1'b0, 8'hC0);
      for (int i = 0; i < 16; i++) bus_write(1'b1, 8'(8'h30 + i));
      check("line2_cur_addr", {25'h0, CUR_ADDR}, 32'h50);
      for (int i = 0; i < 16; i++) side_check(16 + i, 8'(8'h30 + i));
      bus_write(1'b1, 8'h7A);
      check("overrun_cur_addr", {25'h0, CUR_ADDR}, 32'h51);
      side_check(31, 8'h3F);
      side_check(0, 8'h41);

      // Wrap from 0x27 forward, then 0x40 backward.
      bus_write(1'b0, 8'hA7);
      bus_write(1'b1, 8'h55);
      check("wrap_inc_ac", {25'h0, CUR_ADDR}, 32'h40);
      bus_write(1'b0, 8'h04);
      check("entry_dec", {31'h0, ENTRY_ID}, 32'h0);
      bus_write(1'b1, 8'h66);
      side_check(16, 8'h66);
      check("wrap_dec_ac", {25'h0, CUR_ADDR}, 32'h27);
      bus_write(1'b0, 8'h06);

      // Clear with a write and a status read landing inside the busy window.
      bus_write(1'b0, 8'h01);
      check("clear_busy", {31'h0, BUSY}, 32'h1);
      tick(2);
      bus_write(1'b1, 8'h58);
      check("clear_err_busy", {31'h0, ERR_BUSY}, 32'h1);
      check("clear_ac", {25'h0, CUR_ADDR}, 32'h00);
      check("clear_entry_id", {31'h0, ENTRY_ID}, 32'h1);
      bus_read(1'b0, rd, oe);
      check("clear_status", {24'h0, rd}, 32'h80);
      check("clear_status_oe", {31'h0, oe}, 32'h1);
      wait_cnt = 0;
      while (BUSY && wait_cnt < 100) begin
         tick(1);
         wait_cnt++;
      end
      check("clear_busy_drop", {31'h0, BUSY}, 32'h0);
      for (int i = 0; i < 32; i++) side_check(i, 8'h20);

      // Reset in the middle of a clear.
      bus_write(1'b0, 8'hCF);
      bus_write(1'b1, 8'h5A);
      side_check(31, 8'h5A);
      bus_write(1'b0, 8'h01);
      tick(3);
      check("midclear_busy", {31'h0, BUSY}, 32'h1);
      RESETN = 1'b0;
      tick(1);
      check("rst_mid_ac",       {25'h0, CUR_ADDR}, 32'h00);
      check("rst_mid_disp_on",  {31'h0, DISP_ON},  32'h0);
      check("rst_mid_err_busy", {31'h0, ERR_BUSY}, 32'h0);
      check("rst_mid_busy",     {31'h0, BUSY},     32'h0);
      RESETN = 1'b1;
      for (int i = 0; i < 32; i++) side_check(i, 8'h20);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
